// File: rtl/track_scroller_if.sv
// Note-spawn handshake between the chart sequencer (master) and the track scroller (slave).
interface track_scroller_if #(
  parameter int unsigned LEN_W = 9
) ();
  logic             note_valid;
  logic             note_ready;
  logic [2:0]       note_track;
  logic [LEN_W-1:0] note_len;

  modport master (output note_valid, note_track, note_len, input note_ready);
  modport slave  (input note_valid, note_track, note_len, output note_ready);
endinterface

// File: rtl/track_scroller.sv
// Six scrolling track bitmaps: injects notes at row 0 and shifts all tracks down one row per tick.
// Rows leaving the bottom raise a one-cycle per-track exit flag.
module track_scroller #(
  parameter int unsigned ROWS     = 480,
  parameter int unsigned TICK_DIV = 416667,
  parameter int unsigned MIN_GAP  = 4,
  parameter int unsigned LEN_W    = 9
) (
  input  logic                OriginalClk,
  input  logic                Reset,
  input  logic                pause,
  input  logic                clear,
  track_scroller_if.slave     note,
  output logic                scroll_tick,
  output logic [5:0]          track_exit,
  output logic [ROWS-1:0]     track1_data,
  output logic [ROWS-1:0]     track2_data,
  output logic [ROWS-1:0]     track3_data,
  output logic [ROWS-1:0]     track4_data,
  output logic [ROWS-1:0]     track5_data,
  output logic [ROWS-1:0]     track6_data
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GapW = $clog2(MIN_GAP + 2);
  localparam logic [CntW-1:0]  CntLast = CntW'(TICK_DIV - 1);
  localparam logic [GapW-1:0]  GapInit = GapW'(MIN_GAP);
  localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);

  logic [CntW-1:0]  cnt_q;
  logic             tick_q;
  logic [5:0]       exit_q;
  logic [ROWS-1:0]  data_q   [6];
  logic [LEN_W-1:0] remain_q [6];
  logic [GapW-1:0]  gap_q    [6];

  logic [5:0] free;
  logic [7:0] free_ext;
  logic       accept;

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      free[k] = (remain_q[k] == '0) && (gap_q[k] == '0);
    end
  end

  // Padded so track codes 0 and 7 index a constant 0 and are never ready.
  assign free_ext = {1'b0, free, 1'b0};

  assign note.note_ready = !clear && (note.note_len != '0) && free_ext[note.note_track];
  assign accept          = note.note_valid && note.note_ready;

  always_ff @(posedge OriginalClk or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      exit_q <= '0;
      for (int k = 0; k < 6; k++) begin
        data_q[k]   <= '0;
        remain_q[k] <= '0;
        gap_q[k]    <= '0;
      end
    end else if (clear) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      exit_q <= '0;
      for (int k = 0; k < 6; k++) begin
        data_q[k]   <= '0;
        remain_q[k] <= '0;
        gap_q[k]    <= '0;
      end
    end else begin
      if (!pause) begin
        cnt_q  <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        tick_q <= (cnt_q == CntLast);
      end else begin
        tick_q <= 1'b0;
      end
      exit_q <= '0;
      for (int k = 0; k < 6; k++) begin
        if (tick_q) begin
          data_q[k] <= {data_q[k][ROWS-2:0], remain_q[k] != '0};
          exit_q[k] <= data_q[k][ROWS-1];
          if (remain_q[k] > LenOne) begin
            remain_q[k] <= remain_q[k] - 1'b1;
          end else if (remain_q[k] == LenOne) begin
            remain_q[k] <= '0;
            gap_q[k]    <= GapInit;
          end else if (gap_q[k] != '0) begin
            gap_q[k] <= gap_q[k] - 1'b1;
          end
        end
        // An accepted track was free, so the tick above left it untouched; the load wins.
        if (accept && (note.note_track == 3'(k + 1))) begin
          remain_q[k] <= note.note_len;
        end
      end
    end
  end

  assign scroll_tick = tick_q;
  assign track_exit  = exit_q;
  assign track1_data = data_q[0];
  assign track2_data = data_q[1];
  assign track3_data = data_q[2];
  assign track4_data = data_q[3];
  assign track5_data = data_q[4];
  assign track6_data = data_q[5];

endmodule

// File: tb/tb_track_scroller.sv
// Randomised and directed bench for track_scroller against a queue-based behavioural model.
module tb_track_scroller;

  localparam int unsigned ROWS     = 480;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned MIN_GAP  = 4;
  localparam int unsigned LEN_W    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic clr = 1'b0;
  logic scroll_tick;
  logic [5:0] track_exit;
  logic [ROWS-1:0] d [6];

  int vectors = 0;
  int errs = 0;
  int ex1 = 0;
  bit run_cmp = 1'b0;

  track_scroller_if #(.LEN_W(LEN_W)) bus ();

  track_scroller #(
    .ROWS(ROWS), .TICK_DIV(TICK_DIV), .MIN_GAP(MIN_GAP), .LEN_W(LEN_W)
  ) dut (
    .OriginalClk(clk),
    .Reset(rst),
    .pause(pause),
    .clear(clr),
    .note(bus),
    .scroll_tick(scroll_tick),
    .track_exit(track_exit),
    .track1_data(d[0]),
    .track2_data(d[1]),
    .track3_data(d[2]),
    .track4_data(d[3]),
    .track5_data(d[4]),
    .track6_data(d[5])
  );

  always #5 clk = ~clk;

  // Model: each track has a queue of rows still to be fed in at row 0 (note 1s then gap 0s).
  bit [ROWS-1:0] m_data [6];
  bit            m_q [6][$];
  bit            m_tick;
  bit [5:0]      m_exit;
  int unsigned   m_active;

  function automatic bit m_ready();
    int t;
    t = int'(bus.note_track);
    if (clr || t < 1 || t > 6 || bus.note_len == '0) return 1'b0;
    return m_q[t-1].size() == 0;
  endfunction

  function automatic void m_wipe();
    for (int k = 0; k < 6; k++) begin
      m_data[k] = '0;
      m_q[k].delete();
    end
    m_tick   = 1'b0;
    m_exit   = '0;
    m_active = 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      m_wipe();
    end else begin
      bit acc;
      acc = bus.note_valid && m_ready();
      m_exit = '0;
      if (m_tick) begin
        for (int k = 0; k < 6; k++) begin
          bit inj;
          inj = 1'b0;
          if (m_q[k].size() > 0) inj = m_q[k].pop_front();
          m_exit[k] = m_data[k][ROWS-1];
          m_data[k] = {m_data[k][ROWS-2:0], inj};
        end
      end
      if (acc) begin
        for (int i = 0; i < int'(bus.note_len); i++) m_q[bus.note_track-1].push_back(1'b1);
        for (int i = 0; i < int'(MIN_GAP); i++) m_q[bus.note_track-1].push_back(1'b0);
      end
      if (!pause) begin
        m_tick = (m_active % TICK_DIV) == (TICK_DIV - 1);
        m_active++;
      end else begin
        m_tick = 1'b0;
      end
    end
  end

  function automatic void chk(string name, logic [ROWS-1:0] act, logic [ROWS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("scroll_tick", ROWS'(scroll_tick), ROWS'(m_tick));
      chk("track_exit", ROWS'(track_exit), ROWS'(m_exit));
      for (int k = 0; k < 6; k++) chk($sformatf("track%0d_data", k + 1), d[k], m_data[k]);
      chk("note_ready", ROWS'(bus.note_ready), ROWS'(m_ready()));
      if (track_exit[0]) ex1++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc = 0;
    while (seen < n && cyc < 10 * n + 20) begin
      @(negedge clk);
      if (scroll_tick) seen++;
      cyc++;
    end
    if (seen < n) begin
      vectors++;
      errs++;
      $display("FAIL wait_ticks: saw %0d ticks, required %0d", seen, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int trk, input int len);
    int n;
    n = 0;
    bus.note_valid = 1'b1;
    bus.note_track = 3'(trk);
    bus.note_len   = LEN_W'(len);
    #1;
    while (!bus.note_ready && n < 5000) begin
      step();
      #1;
      n++;
    end
    if (n >= 5000) begin
      vectors++;
      errs++;
      $display("FAIL send_timeout: track %0d never ready, required ready", trk);
    end
    step();
    bus.note_valid = 1'b0;
  endtask

  initial begin
    int tp;
    int nwait;
    bus.note_valid = 1'b0;
    bus.note_track = 3'd0;
    bus.note_len   = '0;
    repeat (3) step();
    run_cmp = 1'b1;
    rst = 1'b0;

    // Idle after reset: a tick every 4 cycles, tracks empty.
    tp = 0;
    repeat (20) begin
      @(negedge clk);
      if (scroll_tick) tp++;
      @(posedge clk);
      #1;
    end
    chk("idle_tick_count", ROWS'(tp), ROWS'(4));
    chk("idle_track3", d[2], '0);

    // Track 3, length 5.
    send(3, 5);
    wait_ticks(5);
    chk("t3_after5", ROWS'(d[2][5:0]), ROWS'(6'b011111));
    wait_ticks(1);
    chk("t3_after6", ROWS'(d[2][5:0]), ROWS'(6'b111110));
    chk("t2_untouched", d[1], '0);
    bus.note_track = 3'd3;
    bus.note_len   = LEN_W'(1);
    #1;
    chk("t3_busy_6", ROWS'(bus.note_ready), ROWS'(0));
    wait_ticks(2);
    chk("t3_busy_8", ROWS'(bus.note_ready), ROWS'(0));
    wait_ticks(1);
    chk("t3_free_9", ROWS'(bus.note_ready), ROWS'(1));

    // Track 1, length 2, scrolled fully off the bottom.
    send(1, 2);
    ex1 = 0;
    wait_ticks(483);
    chk("t1_exit_pulses", ROWS'(ex1), ROWS'(2));
    chk("t1_empty", d[0], '0);

    // Invalid requests are never ready.
    bus.note_valid = 1'b1;
    bus.note_track = 3'd0; bus.note_len = LEN_W'(3); #1;
    chk("bad_track0", ROWS'(bus.note_ready), ROWS'(0));
    step();
    bus.note_track = 3'd7; #1;
    chk("bad_track7", ROWS'(bus.note_ready), ROWS'(0));
    step();
    bus.note_track = 3'd2; bus.note_len = '0; #1;
    chk("bad_len0", ROWS'(bus.note_ready), ROWS'(0));
    step();
    bus.note_valid = 1'b0;

    // Accept coinciding with a tick.
    nwait = 0;
    while (!scroll_tick && nwait < 20) begin
      step();
      nwait++;
    end
    bus.note_valid = 1'b1; bus.note_track = 3'd4; bus.note_len = LEN_W'(2); #1;
    chk("t4_ready_on_tick", ROWS'(bus.note_ready), ROWS'(1));
    step();
    bus.note_valid = 1'b0;
    chk("t4_bit0_on_tick", ROWS'(d[3][0]), ROWS'(0));
    wait_ticks(1);
    chk("t4_bit0_next", ROWS'(d[3][0]), ROWS'(1));

    // Pause mid-count for 10 cycles.
    wait_ticks(1);
    step();
    pause = 1'b1;
    tp = 0;
    repeat (10) begin
      @(negedge clk);
      if (scroll_tick) tp++;
      @(posedge clk);
      #1;
    end
    chk("pause_no_ticks", ROWS'(tp), ROWS'(0));
    pause = 1'b0;
    tp = 0;
    nwait = 0;
    while (tp == 0 && nwait < 10) begin
      @(negedge clk);
      nwait++;
      if (scroll_tick) tp = 1;
    end
    chk("resume_latency", ROWS'(nwait), ROWS'(3));
    step();

    // Clear mid-note on track 6.
    send(6, 5);
    wait_ticks(2);
    clr = 1'b1;
    bus.note_track = 3'd6; bus.note_len = LEN_W'(1); #1;
    chk("ready_during_clear", ROWS'(bus.note_ready), ROWS'(0));
    step();
    clr = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) chk($sformatf("clear_t%0d", k + 1), d[k], '0);
    chk("t6_ready_after_clear", ROWS'(bus.note_ready), ROWS'(1));

    // Randomised traffic.
    repeat (3000) begin
      bus.note_valid = 1'($urandom_range(0, 1));
      bus.note_track = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) bus.note_len = '0;
      else if ($urandom_range(0, 19) == 0) bus.note_len = LEN_W'($urandom_range(1, 511));
      else bus.note_len = LEN_W'($urandom_range(1, 30));
      pause = ($urandom_range(0, 11) == 0);
      clr   = ($urandom_range(0, 299) == 0);
      step();
    end
    bus.note_valid = 1'b0;
    pause = 1'b0;
    clr   = 1'b0;
    repeat (40) step();

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk("async_scroll_tick", ROWS'(scroll_tick), ROWS'(0));
    chk("async_exit", ROWS'(track_exit), ROWS'(0));
    for (int k = 0; k < 6; k++) chk($sformatf("async_t%0d", k + 1), d[k], '0);
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
